// File: rtl/exa_crosb_vc_switch.sv
// rtl/exa_crosb_vc_switch.sv - packet-locked crossbar with per-output VC credit flow control
// Define EXA_CROSB_OUT_REG_EN to place a 2-entry skid register on every output.
module exa_crosb_vc_switch #(
  parameter  int DATA_WIDTH = 128,
  parameter  int INPUT_NUM  = 4,
  parameter  int OUTPUT_NUM = 4,
  parameter  int VC_NUM     = 2,
  parameter  int CREDIT_MAX = 8,
  localparam int IN_W       = (INPUT_NUM  > 1) ? $clog2(INPUT_NUM)  : 1,
  localparam int DST_W      = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1,
  localparam int VC_W       = (VC_NUM     > 1) ? $clog2(VC_NUM)     : 1,
  localparam int CR_W       = $clog2(CREDIT_MAX + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [INPUT_NUM*DATA_WIDTH-1:0]  s_tdata,
  input  logic [INPUT_NUM-1:0]             s_tvalid,
  input  logic [INPUT_NUM-1:0]             s_tlast,
  output logic [INPUT_NUM-1:0]             s_tready,
  input  logic [INPUT_NUM*DST_W-1:0]       s_tdest,
  input  logic [INPUT_NUM*VC_W-1:0]        s_tvc,
  output logic [OUTPUT_NUM*DATA_WIDTH-1:0] m_tdata,
  output logic [OUTPUT_NUM-1:0]            m_tvalid,
  output logic [OUTPUT_NUM-1:0]            m_tlast,
  input  logic [OUTPUT_NUM-1:0]            m_tready,
  output logic [OUTPUT_NUM*VC_W-1:0]       m_tvc,
  input  logic [OUTPUT_NUM*VC_NUM-1:0]     i_credit_return,
  output logic [OUTPUT_NUM*IN_W-1:0]       o_selected_input,
  output logic                             o_credit_overflow
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                state_q [OUTPUT_NUM];
  logic [IN_W-1:0]       sel_q   [OUTPUT_NUM];
  logic [VC_W-1:0]       vc_q    [OUTPUT_NUM];
  logic [IN_W-1:0]       rr_q    [OUTPUT_NUM];
  logic [CR_W-1:0]       cr_q    [OUTPUT_NUM][VC_NUM];
  logic [CR_W-1:0]       cr_d    [OUTPUT_NUM][VC_NUM];
  logic                  ovf_q;
  logic                  ovf_d;

  logic                  gnt_vld [OUTPUT_NUM];
  logic [IN_W-1:0]       gnt_idx [OUTPUT_NUM];
  logic [VC_W-1:0]       gnt_vc  [OUTPUT_NUM];
  logic [INPUT_NUM-1:0]  in_locked;
  logic                  in_vld  [OUTPUT_NUM];
  logic                  in_last [OUTPUT_NUM];
  logic [DATA_WIDTH-1:0] in_data [OUTPUT_NUM];
  logic                  cr_ok   [OUTPUT_NUM];
  logic                  out_rdy [OUTPUT_NUM];
  logic                  acc     [OUTPUT_NUM];

`ifdef EXA_CROSB_OUT_REG_EN
  logic [DATA_WIDTH-1:0] data_q  [OUTPUT_NUM][2];
  logic                  last_q  [OUTPUT_NUM][2];
  logic [VC_W-1:0]       mvc_q   [OUTPUT_NUM][2];
  logic                  wp_q    [OUTPUT_NUM];
  logic                  rp_q    [OUTPUT_NUM];
  logic [1:0]            cnt_q   [OUTPUT_NUM];
  logic                  pop     [OUTPUT_NUM];
`endif

  always_comb begin
    in_locked = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      if (state_q[o] == LOCKED) in_locked[sel_q[o]] = 1'b1;
    end
  end

  // Round-robin search from rr_q; scanning backwards lets the closest candidate win.
  always_comb begin
    int idx;
    int vc;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      gnt_vc[o]  = '0;
      for (int k = INPUT_NUM - 1; k >= 0; k--) begin
        idx = (int'(rr_q[o]) + k) % INPUT_NUM;
        vc  = int'(s_tvc[idx*VC_W +: VC_W]);
        if (state_q[o] == IDLE && s_tvalid[idx] && !in_locked[idx] &&
            int'(s_tdest[idx*DST_W +: DST_W]) == o && vc < VC_NUM &&
            cr_q[o][vc] != '0) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = IN_W'(idx);
          gnt_vc[o]  = VC_W'(vc);
        end
      end
    end
  end

  always_comb begin
    s_tready = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      in_vld[o]  = s_tvalid[sel_q[o]];
      in_last[o] = s_tlast[sel_q[o]];
      in_data[o] = s_tdata[int'(sel_q[o])*DATA_WIDTH +: DATA_WIDTH];
      cr_ok[o]   = (state_q[o] == LOCKED) && (cr_q[o][vc_q[o]] != '0);
`ifdef EXA_CROSB_OUT_REG_EN
      out_rdy[o] = cr_ok[o] && (cnt_q[o] != 2'd2);
      pop[o]     = (cnt_q[o] != 2'd0) && m_tready[o];
`else
      out_rdy[o] = cr_ok[o] && m_tready[o];
`endif
      acc[o] = out_rdy[o] && in_vld[o];
      if (out_rdy[o]) s_tready[sel_q[o]] = 1'b1;
    end
  end

  always_comb begin
    m_tdata          = '0;
    m_tvalid         = '0;
    m_tlast          = '0;
    m_tvc            = '0;
    o_selected_input = '0;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      o_selected_input[o*IN_W +: IN_W] = sel_q[o];
`ifdef EXA_CROSB_OUT_REG_EN
      m_tvalid[o] = (cnt_q[o] != 2'd0);
      m_tlast[o]  = m_tvalid[o] && last_q[o][rp_q[o]];
      m_tdata[o*DATA_WIDTH +: DATA_WIDTH] = m_tvalid[o] ? data_q[o][rp_q[o]] : '0;
      m_tvc[o*VC_W +: VC_W] = m_tvalid[o] ? mvc_q[o][rp_q[o]] : vc_q[o];
`else
      m_tvalid[o] = cr_ok[o] && in_vld[o];
      m_tlast[o]  = m_tvalid[o] && in_last[o];
      m_tdata[o*DATA_WIDTH +: DATA_WIDTH] = (state_q[o] == LOCKED) ? in_data[o] : '0;
      m_tvc[o*VC_W +: VC_W] = vc_q[o];
`endif
    end
  end

  // Simultaneous consume and return cancel; a lone return at full is dropped and flagged.
  always_comb begin
    logic ret;
    logic cons;
    ovf_d = ovf_q;
    for (int o = 0; o < OUTPUT_NUM; o++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        ret        = i_credit_return[o*VC_NUM + v];
        cons       = acc[o] && (int'(vc_q[o]) == v);
        cr_d[o][v] = cr_q[o][v];
        if (cons && !ret) begin
          cr_d[o][v] = cr_q[o][v] - 1'b1;
        end else if (ret && !cons) begin
          if (cr_q[o][v] == CR_W'(CREDIT_MAX)) ovf_d = 1'b1;
          else cr_d[o][v] = cr_q[o][v] + 1'b1;
        end
      end
    end
  end

  assign o_credit_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      for (int o = 0; o < OUTPUT_NUM; o++) begin
        state_q[o] <= IDLE;
        sel_q[o]   <= '0;
        vc_q[o]    <= '0;
        rr_q[o]    <= '0;
        for (int v = 0; v < VC_NUM; v++) cr_q[o][v] <= CR_W'(CREDIT_MAX);
`ifdef EXA_CROSB_OUT_REG_EN
        wp_q[o]  <= 1'b0;
        rp_q[o]  <= 1'b0;
        cnt_q[o] <= 2'd0;
`endif
      end
    end else begin
      ovf_q <= ovf_d;
      for (int o = 0; o < OUTPUT_NUM; o++) begin
        for (int v = 0; v < VC_NUM; v++) cr_q[o][v] <= cr_d[o][v];
        case (state_q[o])
          IDLE: begin
            if (gnt_vld[o]) begin
              state_q[o] <= LOCKED;
              sel_q[o]   <= gnt_idx[o];
              vc_q[o]    <= gnt_vc[o];
            end
          end
          LOCKED: begin
            if (acc[o] && in_last[o]) begin
              state_q[o] <= IDLE;
              rr_q[o]    <= (int'(sel_q[o]) == INPUT_NUM - 1) ? '0 : sel_q[o] + 1'b1;
            end
          end
          default: state_q[o] <= IDLE;
        endcase
`ifdef EXA_CROSB_OUT_REG_EN
        if (acc[o]) begin
          data_q[o][wp_q[o]] <= in_data[o];
          last_q[o][wp_q[o]] <= in_last[o];
          mvc_q[o][wp_q[o]]  <= vc_q[o];
          wp_q[o]            <= ~wp_q[o];
        end
        if (pop[o]) rp_q[o] <= ~rp_q[o];
        if (acc[o] && !pop[o]) cnt_q[o] <= cnt_q[o] + 2'd1;
        else if (!acc[o] && pop[o]) cnt_q[o] <= cnt_q[o] - 2'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_exa_crosb_vc_switch.sv
// tb/tb_exa_crosb_vc_switch.sv - scoreboard bench for exa_crosb_vc_switch
module tb_exa_crosb_vc_switch;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int NV = 2;
  localparam int CM = 4;
`ifdef EXA_CROSB_OUT_REG_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          vc;
    int            src;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [DW-1:0] td [NI];
  logic          tv [NI];
  logic          tl [NI];
  logic [1:0]    tdst [NI];
  logic          tvc [NI];

  logic [NI*DW-1:0] s_tdata;
  logic [NI-1:0]    s_tvalid, s_tlast, s_tready, s_tvc;
  logic [NI*2-1:0]  s_tdest;
  logic [NO*DW-1:0] m_tdata;
  logic [NO-1:0]    m_tvalid, m_tlast, m_tready, m_tvc;
  logic [NO*NV-1:0] cret;
  logic [NO*2-1:0]  sel;
  logic             ovf;

  exp_t sbq [NO][$];
  int   rx_cnt [NO];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      s_tdata[i*DW +: DW] = td[i];
      s_tvalid[i]         = tv[i];
      s_tlast[i]          = tl[i];
      s_tdest[i*2 +: 2]   = tdst[i];
      s_tvc[i]            = tvc[i];
    end
  end

  exa_crosb_vc_switch #(
    .DATA_WIDTH(DW), .INPUT_NUM(NI), .OUTPUT_NUM(NO), .VC_NUM(NV), .CREDIT_MAX(CM)
  ) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .s_tdest(s_tdest), .s_tvc(s_tvc),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .m_tvc(m_tvc), .i_credit_return(cret), .o_selected_input(sel),
    .o_credit_overflow(ovf)
  );

  function automatic logic [DW-1:0] mk_data(input int src, input int id, input int f);
    return {8'(src), 8'(id), 16'(f)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int dst, input int src, input int vc, input int len, input int id);
    exp_t e;
    for (int f = 0; f < len; f++) begin
      e.data = mk_data(src, id, f);
      e.last = (f == len - 1);
      e.vc   = vc[0];
      e.src  = src;
      sbq[dst].push_back(e);
    end
  endtask

  // Entered at posedge+1; each flit is held until s_tready is seen at a negedge.
  task automatic send_pkt(input int src, input int dst, input int vc, input int len, input int id);
    for (int f = 0; f < len; f++) begin
      int  n;
      logic ok;
      n  = 0;
      ok = 1'b0;
      tv[src]   = 1'b1;
      td[src]   = mk_data(src, id, f);
      tl[src]   = (f == len - 1);
      tdst[src] = 2'(dst);
      tvc[src]  = vc[0];
      while (!ok && n < 300) begin
        @(negedge clk);
        ok = s_tready[src];
        @(posedge clk);
        #1;
        n++;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL send_timeout in%0d flit %0d: got no s_tready expected s_tready=1", src, f);
      end
    end
    tv[src] = 1'b0;
    tl[src] = 1'b0;
  endtask

  task automatic wait_rx(input int o, input int n, input string name);
    int k;
    k = 0;
    while (rx_cnt[o] < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, rx_cnt[o], n);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int o = 0; o < NO; o++) begin
          if (m_tvalid[o] && m_tready[o]) begin
            rx_cnt[o]++;
            if (sbq[o].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_flit out%0d: got %0h expected none", o, m_tdata[o*DW +: DW]);
            end else begin
              e = sbq[o].pop_front();
              check($sformatf("out%0d_data", o), m_tdata[o*DW +: DW], e.data);
              check($sformatf("out%0d_last", o), m_tlast[o], e.last);
              check($sformatf("out%0d_vc", o), m_tvc[o], e.vc);
`ifndef EXA_CROSB_OUT_REG_EN
              check($sformatf("out%0d_sel", o), sel[o*2 +: 2], e.src[1:0]);
`endif
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      tv[i] = 1'b0;
      tl[i] = 1'b0;
    end
    cret = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int o = 0; o < NO; o++) rx_cnt[o] = 0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      td[i] = '0; tv[i] = 1'b0; tl[i] = 1'b0; tdst[i] = '0; tvc[i] = 1'b0;
    end
    for (int o = 0; o < NO; o++) rx_cnt[o] = 0;
    m_tready = '1;
    cret     = '0;
    fork
      monitor();
    join_none

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tvc", m_tvc, 0);
    check("rst_sel", sel, 0);
    check("rst_ovf", ovf, 0);
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++)
        check($sformatf("rst_credit_%0d_%0d", o, v), dut.cr_q[o][v], CM);

    // 3-flit packet in0 -> out2 VC1, first-valid latency
    do_reset();
    push_pkt(2, 0, 1, 3, 1);
    fork
      send_pkt(0, 2, 1, 3, 1);
      begin
        int first_n;
        first_n = 0;
        for (int n = 1; n <= 20; n++) begin
          @(negedge clk);
          if (m_tvalid[2]) begin
            first_n = n;
            break;
          end
        end
        check("s033_first_valid_cycle", first_n, EXP_LAT);
      end
    join
    repeat (3) @(negedge clk);
    check("s033_rx", rx_cnt[2], 3);
    check("s033_credit", dut.cr_q[2][1], 1);

    // Same packet with m_tready toggling
    do_reset();
    push_pkt(2, 0, 1, 3, 2);
    m_tready[2] = 1'b0;
    fork
      send_pkt(0, 2, 1, 3, 2);
      begin
        for (int n = 0; n < 30; n++) begin
          @(posedge clk);
          #1;
          m_tready[2] = ~m_tready[2];
        end
        m_tready[2] = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    check("s038_rx", rx_cnt[2], 3);

    // Three inputs contend for out0; served 0,1,3 whole packets
    do_reset();
    push_pkt(0, 0, 0, 2, 10);
    push_pkt(0, 1, 0, 2, 11);
    push_pkt(0, 3, 1, 2, 13);
    fork
      send_pkt(0, 0, 0, 2, 10);
      send_pkt(1, 0, 0, 2, 11);
      send_pkt(3, 0, 1, 2, 13);
    join
    repeat (3) @(negedge clk);
    check("s034_rx", rx_cnt[0], 6);

    // Credit exhaustion mid-packet, then resume on returns
    do_reset();
    push_pkt(1, 1, 0, 6, 20);
    fork
      send_pkt(1, 1, 0, 6, 20);
      begin
        wait_rx(1, 4, "s035_first4");
        repeat (4) @(negedge clk);
        check("s035_stall_mvalid", m_tvalid[1], 0);
        check("s035_stall_sready", s_tready[1], 0);
        check("s035_stall_lock", sel[3:2], 1);
        check("s035_stall_rx", rx_cnt[1], 4);
        check("s035_stall_credit", dut.cr_q[1][0], 0);
        @(posedge clk);
        #1 cret[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1 cret[2] = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("s035_rx", rx_cnt[1], 6);
    check("s035_credit", dut.cr_q[1][0], 0);

    // Return coinciding with acceptance, then overflow at full
    do_reset();
    push_pkt(3, 2, 0, 1, 5);
    fork
      send_pkt(2, 3, 0, 1, 5);
      begin
        @(posedge clk);
        #1 cret[6] = 1'b1;
        @(posedge clk);
        #1 cret[6] = 1'b0;
      end
    join
    @(negedge clk);
    check("s036_same_cycle_credit", dut.cr_q[3][0], CM);
    check("s036_no_ovf", ovf, 0);
    @(posedge clk);
    #1 cret[6] = 1'b1;
    @(posedge clk);
    #1 cret[6] = 1'b0;
    @(negedge clk);
    check("s036_ovf_set", ovf, 1);
    check("s036_ovf_credit", dut.cr_q[3][0], CM);
    repeat (3) @(negedge clk);
    check("s036_ovf_sticky", ovf, 1);

    // Reset mid-packet, then a fresh packet routes normally
    do_reset();
    check("s037_ovf_cleared", ovf, 0);
    push_pkt(1, 0, 0, 1, 30);
`ifndef EXA_CROSB_OUT_REG_EN
    sbq[1].push_back('{data: mk_data(0, 30, 1), last: 1'b0, vc: 1'b0, src: 0});
`endif
    sbq[1][0].last = 1'b0;
    begin
      int got;
      int n;
      got = 0;
      n   = 0;
      tv[0] = 1'b1; tl[0] = 1'b0; tdst[0] = 2'd1; tvc[0] = 1'b0;
      while (got < 2 && n < 50) begin
        td[0] = mk_data(0, 30, got);
        @(negedge clk);
        if (s_tready[0]) got++;
        @(posedge clk);
        #1;
        n++;
      end
      check("s037_two_accepted", got, 2);
    end
    reset = 1'b1;
    tv[0] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("s037_sready", s_tready, 0);
    check("s037_mvalid", m_tvalid, 0);
    check("s037_sel", sel, 0);
    for (int v = 0; v < NV; v++)
      check($sformatf("s037_credit_1_%0d", v), dut.cr_q[1][v], CM);
    check("s037_drained", sbq[1].size(), 0);
    @(posedge clk);
    #1;
    for (int o = 0; o < NO; o++) rx_cnt[o] = 0;
    push_pkt(1, 2, 1, 3, 31);
    send_pkt(2, 1, 1, 3, 31);
    repeat (3) @(negedge clk);
    check("s037_new_rx", rx_cnt[1], 3);

    for (int o = 0; o < NO; o++)
      check($sformatf("end_queue_out%0d", o), sbq[o].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
